button_conditioner: RTL

Input-conditioning stage directly upstream of the game controller: takes the five raw, asynchronous GPIO push-buttons (up, down, left, right, select) and produces clean, clock-synchronous debounced levels plus single-cycle press pulses. Direction buttons get optional auto-repeat so a held button keeps moving the cursor. The game controller consumes `btn_press`; `btn_level` is available to the logger and to any other observer.

---
 rtl/button_conditioner_if.sv | 24 ++
 rtl/button_conditioner.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// Button-conditioner bus: raw GPIO buttons in, debounced levels and press pulses out.
// The slave modport is the conditioner; the master is whoever drives the raw inputs.
interface button_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic             any_press;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output any_press
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debouncer and auto-repeater; emits debounced levels and
// registered one-cycle press pulses (initial press plus repeats) for the game controller.
module button_conditioner #(
  parameter int          N_BTN           = 5,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          REPEAT_DELAY    = 25000000,
  parameter int          REPEAT_RATE     = 7500000,
  parameter logic [4:0]  REPEAT_MASK     = 5'b01111
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press_next;
  logic [N_BTN-1:0] r_press;
  logic             r_any;

  // NOTE: asynchronous active-high reset; every flop clears the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      // NOTE: non-blocking so r_sync2 takes the old r_sync1, forming a real two-flop chain.
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          r_db;
    logic [DW-1:0] r_dcnt;
    logic          w_db_nxt;
    logic [DW-1:0] w_dcnt_nxt;
    logic          w_rise;

    rep_state_t    r_state;
    rep_state_t    w_state_nxt;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_rep;

    // Count consecutive cycles the synchronized input disagrees with the accepted level.
    always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      w_db_nxt   = r_db;
      w_dcnt_nxt = '0;
      if (r_sync2[i] != r_db) begin
        if (r_dcnt == DB_LAST) begin
          w_db_nxt = r_sync2[i];
        end else begin
          w_dcnt_nxt = r_dcnt + DW'(1);
        end
      end
    end

    assign w_rise = ~r_db & w_db_nxt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_db   <= 1'b0;
        r_dcnt <= '0;
      end else begin
        r_db   <= w_db_nxt;
        r_dcnt <= w_dcnt_nxt;
      end
    end

    // Release is judged on the incoming level so no repeat escapes in the falling cycle.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_rep       = 1'b0;
      if (!REPEAT_MASK[i] || !w_db_nxt) begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              w_state_nxt = DELAY;
              w_rcnt_nxt  = '0;
            end
          end
          DELAY: begin
            if (r_rcnt == DELAY_LAST) begin
              w_rep       = 1'b1;
              w_rcnt_nxt  = '0;
              w_state_nxt = REPEAT;
            end else begin
              w_rcnt_nxt = r_rcnt + RW'(1);
            end
          end
          REPEAT: begin
            if (r_rcnt == RATE_LAST) begin
              w_rep      = 1'b1;
              w_rcnt_nxt = '0;
            end else begin
              w_rcnt_nxt = r_rcnt + RW'(1);
            end
          end
          default: begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_rcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
      end
    end

    assign w_level[i]      = r_db;
    assign w_press_next[i] = w_rise | w_rep;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_press <= '0;
      r_any   <= 1'b0;
    end else begin
      r_press <= w_press_next;
      r_any   <= |w_press_next;
    end
  end

  assign bus.btn_level = w_level;
  assign bus.btn_press = r_press;
  assign bus.any_press = r_any;

endmodule
